// File: rtl/if_id_fifo.sv
// IF/ID fetch queue: DEPTH-entry circular buffer with valid/ready handshakes on both sides.
// The head entry is presented pre-split into decode fields; an empty queue shows an all-zero NOP.
module if_id_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_WIDTH-1:0]      nxt_pc,
  input  logic [31:0]              inst_in,
  input  logic                     if_id_write,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [5:0]               op_code,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [15:0]              imm,
  output logic [5:0]               funct_out,
  output logic [25:0]              target_out,
  output logic [PC_WIDTH-1:0]      pc_out,
  output logic [3:0]               top4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CountFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CountOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  logic [PC_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem_d   [DEPTH];
  logic [31:0]         inst_mem_q [DEPTH];
  logic [31:0]         inst_mem_d [DEPTH];
  logic [AW-1:0]       wp_q, wp_d;
  logic [AW-1:0]       rp_q, rp_d;
  logic [AW:0]         count_q, count_d;

  logic                push, pop, not_empty;
  logic [31:0]         head_inst;
  logic [PC_WIDTH-1:0] head_pc;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != CountFull);
  assign out_valid = not_empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & if_id_write;

  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    if (flush) begin
      // Redirect: drop everything, including any same-cycle push or pop.
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_mem_d[wp_q]   = nxt_pc;
        inst_mem_d[wp_q] = inst_in;
        wp_d             = wp_q + PtrOne;
      end
      if (pop) begin
        rp_d = rp_q + PtrOne;
      end
      if (push && !pop) begin
        count_d = count_q + CountOne;
      end else if (pop && !push) begin
        count_d = count_q - CountOne;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; an empty queue masks it at the outputs instead.
  always_ff @(posedge clock) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

  always_comb begin
    head_inst = '0;
    head_pc   = '0;
    if (not_empty) begin
      head_inst = inst_mem_q[rp_q];
      head_pc   = pc_mem_q[rp_q];
    end
  end

  assign op_code    = head_inst[31:26];
  assign rs         = head_inst[25:21];
  assign rt         = head_inst[20:16];
  assign rd         = head_inst[15:11];
  assign imm        = head_inst[15:0];
  assign funct_out  = head_inst[5:0];
  assign target_out = head_inst[25:0];
  assign pc_out     = head_pc;
  assign top4       = head_pc[PC_WIDTH-1 -: 4];
  assign count      = count_q;

endmodule
